// File: rtl/multi_freq_div_pkg.sv
// Shared constants, types and helpers for the multi-channel clock divider.
package multi_freq_div_pkg;

    localparam int unsigned DEF_CNT_W    = 12;
    localparam int unsigned DEF_HALF_CYC = 6;

    typedef logic [DEF_CNT_W-1:0] half_t;

    // A half-period of zero would never reach a boundary; treat it as one.
    function automatic logic [31:0] clamp_half(input logic [31:0] v);
        return (v == '0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/multi_freq_div_ch.sv
// One divider channel: half-period counter, active/shadow half-period, toggle and tick.
module freq_div_ch #(
    parameter int unsigned CNT_W    = 12,
    parameter int unsigned DEF_HALF = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [CNT_W-1:0] half_i,
    input  logic             sync_clr_i,
    output logic             pending_o,
    output logic             clk_div_o,
    output logic             tick_o
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_RS = CNT_W'(DEF_HALF);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             div_q, div_d;
    logic             tick_q, tick_d;
    logic             toggle;

    always_comb begin
        toggle    = en_i && (count_q == active_q - ONE);
        count_d   = count_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        div_d     = div_q;
        tick_d    = 1'b0;
        if (sync_clr_i) begin
            count_d = '0;
            div_d   = 1'b0;
            if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end else if (toggle) begin
            count_d = '0;
            div_d   = ~div_q;
            tick_d  = ~div_q;
            if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end else if (en_i) begin
            count_d = count_q + ONE;
        end
        // A write on a boundary edge lands after the swap, so it waits for the next one.
        if (we_i) begin
            shadow_d  = half_i;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            active_q  <= HALF_RS;
            shadow_q  <= HALF_RS;
            pending_q <= 1'b0;
            div_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            div_q     <= div_d;
            tick_q    <= tick_d;
        end
    end

    assign pending_o = pending_q;
    assign clk_div_o = div_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/multi_freq_div.sv
// Multi-channel programmable clock divider top: config decode and channel array.
// Optional CLK_DIV_SYNC_EN adds a sync_clr input that phase-aligns all channels.
module multi_freq_div
    import multi_freq_div_pkg::*;
#(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned DEF_HALF = DEF_HALF_CYC,
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef CLK_DIV_SYNC_EN
    input  logic              sync_clr,
`endif
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic [NUM_CH-1:0] cfg_pending,
    output logic [NUM_CH-1:0] clk_div,
    output logic [NUM_CH-1:0] tick
);

    logic [CNT_W-1:0]  half_cl;
    logic [NUM_CH-1:0] we_ch;
    logic              sync_int;

    assign half_cl = CNT_W'(clamp_half(32'(cfg_half)));

`ifdef CLK_DIV_SYNC_EN
    assign sync_int = sync_clr;
`else
    assign sync_int = 1'b0;
`endif

    for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
        // Out-of-range channel numbers match no channel and are dropped here.
        assign we_ch[i] = cfg_we && (32'(cfg_ch) == i);

        freq_div_ch #(
            .CNT_W   (CNT_W),
            .DEF_HALF(DEF_HALF)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .en_i      (en[i]),
            .we_i      (we_ch[i]),
            .half_i    (half_cl),
            .sync_clr_i(sync_int),
            .pending_o (cfg_pending[i]),
            .clk_div_o (clk_div[i]),
            .tick_o    (tick[i])
        );
    end

endmodule

// File: tb/tb_multi_freq_div.sv
// Self-checking bench for multi_freq_div: countdown reference model plus directed literal checks.
module tb_multi_freq_div;

    localparam int NCH  = 2;
    localparam int DEFH = 6;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           sync_clr = 1'b0;
    logic [NCH-1:0] en = '0;
    logic           cfg_we = 1'b0;
    logic [0:0]     cfg_ch = '0;
    logic [11:0]    cfg_half = '0;
    logic [NCH-1:0] cfg_pending, clk_div, tick;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // Reference model: each channel counts down the cycles left in its half-period.
    int             m_half[NCH], m_shadow[NCH], m_rem[NCH];
    logic [NCH-1:0] m_div, m_tick, m_pend;

    multi_freq_div #(
        .NUM_CH  (NCH),
        .CNT_W   (12),
        .DEF_HALF(DEFH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef CLK_DIV_SYNC_EN
        .sync_clr   (sync_clr),
`endif
        .en         (en),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_half   (cfg_half),
        .cfg_pending(cfg_pending),
        .clk_div    (clk_div),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc    = 0;
            m_div  = '0;
            m_tick = '0;
            m_pend = '0;
            for (int c = 0; c < NCH; c++) begin
                m_half[c]   = DEFH;
                m_shadow[c] = DEFH;
                m_rem[c]    = DEFH;
            end
        end else begin
            cyc++;
            for (int c = 0; c < NCH; c++) begin
                m_tick[c] = 1'b0;
                if (sync_clr) begin
                    m_div[c] = 1'b0;
                    if (m_pend[c]) begin
                        m_half[c] = m_shadow[c];
                        m_pend[c] = 1'b0;
                    end
                    m_rem[c] = m_half[c];
                end else if (en[c]) begin
                    m_rem[c]--;
                    if (m_rem[c] == 0) begin
                        m_div[c]  = ~m_div[c];
                        m_tick[c] = m_div[c];
                        if (m_pend[c]) begin
                            m_half[c] = m_shadow[c];
                            m_pend[c] = 1'b0;
                        end
                        m_rem[c] = m_half[c];
                    end
                end
                if (cfg_we && int'(cfg_ch) == c) begin
                    m_shadow[c] = (cfg_half == 0) ? 1 : int'(cfg_half);
                    m_pend[c]   = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %b expected %b (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        else
            n_pass++;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_clk_div", 8'(clk_div), 8'(m_div));
            chk("model_tick", 8'(tick), 8'(m_tick));
            chk("model_pending", 8'(cfg_pending), 8'(m_pend));
        end
    end

    // Wait until k posedges since reset release; one-cycle strobes drop after each edge.
    task automatic adv(input int k);
        while (cyc < k) begin
            @(negedge clk);
            cfg_we   = 1'b0;
            sync_clr = 1'b0;
        end
    endtask

    task automatic do_reset(input logic [NCH-1:0] en_init);
        @(negedge clk);
        rst_n    = 1'b0;
        cfg_we   = 1'b0;
        sync_clr = 1'b0;
        en       = '0;
        @(negedge clk);
        @(negedge clk);
        en    = en_init;
        rst_n = 1'b1;
    endtask

    task automatic wr(input int ch, input int half);
        cfg_we   = 1'b1;
        cfg_ch   = 1'(ch);
        cfg_half = 12'(half);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Defaults after reset: rise after edge 6, fall after 12, tick for one cycle.
        do_reset(2'b11);
        chk("reset_div", 8'(clk_div), 8'h00);
        chk("reset_pend", 8'(cfg_pending), 8'h00);
        adv(5);  chk("def_e5_div", 8'(clk_div), 8'h00);
        adv(6);  chk("def_e6_div", 8'(clk_div), 8'h03);
                 chk("def_e6_tick", 8'(tick), 8'h03);
        adv(7);  chk("def_e7_tick", 8'(tick), 8'h00);
        adv(11); chk("def_e11_div", 8'(clk_div), 8'h03);
        adv(12); chk("def_e12_div", 8'(clk_div), 8'h00);
                 chk("def_e12_tick", 8'(tick), 8'h00);
        adv(18); chk("def_e18_tick", 8'(tick), 8'h03);

        // Reprogramming, clamp, same-edge write and back-to-back writes.
        do_reset(2'b11);
        adv(1);  wr(0, 3);
        adv(2);  chk("wr0_pend", 8'(cfg_pending), 8'h01);
        adv(6);  chk("wr0_e6_div", 8'(clk_div), 8'h03);
                 chk("wr0_e6_pend", 8'(cfg_pending), 8'h00);
        adv(9);  chk("wr0_e9_div", 8'(clk_div), 8'h02);
        adv(12); chk("wr0_e12_div", 8'(clk_div), 8'h01);
        wr(1, 0);
        adv(13); chk("clamp_pend", 8'(cfg_pending), 8'h02);
        adv(18); chk("clamp_e18_div1", 8'(clk_div[1]), 8'h01);
                 chk("clamp_e18_tick1", 8'(tick[1]), 8'h01);
        adv(19); chk("clamp_e19_div1", 8'(clk_div[1]), 8'h00);
        adv(20); chk("clamp_e20_tick1", 8'(tick[1]), 8'h01);
        wr(0, 5);
        adv(21); chk("same_edge_pend", 8'(cfg_pending), 8'h01);
                 chk("same_edge_div0", 8'(clk_div[0]), 8'h00);
        adv(24); chk("same_edge_e24_div0", 8'(clk_div[0]), 8'h01);
                 chk("same_edge_e24_pend", 8'(cfg_pending), 8'h00);
        adv(28); chk("half5_e28_div0", 8'(clk_div[0]), 8'h01);
        adv(29); chk("half5_e29_div0", 8'(clk_div[0]), 8'h00);
        wr(0, 7);
        adv(30); wr(0, 2);
        adv(31); chk("b2b_pend", 8'(cfg_pending), 8'h01);
        adv(34); chk("b2b_e34_div0", 8'(clk_div[0]), 8'h01);
        adv(36); chk("b2b_e36_div0", 8'(clk_div[0]), 8'h00);

        // Enable hold: ch0 frozen at count 3 for five edges, toggles on edge 11.
        do_reset(2'b11);
        adv(3);  en = 2'b10;
        adv(6);  chk("hold_e6_div", 8'(clk_div), 8'h02);
                 chk("hold_e6_tick", 8'(tick), 8'h02);
        adv(8);  chk("hold_e8_div0", 8'(clk_div[0]), 8'h00);
        en = 2'b11;
        adv(10); chk("hold_e10_div0", 8'(clk_div[0]), 8'h00);
        adv(11); chk("hold_e11_div0", 8'(clk_div[0]), 8'h01);
                 chk("hold_e11_tick0", 8'(tick[0]), 8'h01);

        // Asynchronous reset mid-cycle with tick high and a pending write.
        do_reset(2'b11);
        adv(5);  wr(1, 4);
        adv(6);  chk("pre_rst_tick", 8'(tick), 8'h03);
                 chk("pre_rst_pend", 8'(cfg_pending), 8'h02);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_div", 8'(clk_div), 8'h00);
        chk("async_rst_tick", 8'(tick), 8'h00);
        chk("async_rst_pend", 8'(cfg_pending), 8'h00);

`ifdef CLK_DIV_SYNC_EN
        // Misalign the channels, then realign with sync_clr.
        do_reset(2'b01);
        adv(2);  en = 2'b11;
        adv(4);  sync_clr = 1'b1;
        adv(5);  chk("sync_e5_div", 8'(clk_div), 8'h00);
        adv(10); chk("sync_e10_div", 8'(clk_div), 8'h00);
        adv(11); chk("sync_e11_div", 8'(clk_div), 8'h03);
                 chk("sync_e11_tick", 8'(tick), 8'h03);
`endif

        do_reset(2'b11);
        adv(3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
